// File: rtl/dma_credit_sched.sv
// dma_credit_sched
// Round-robin request scheduler for a DMA front end with per-region credit
// limiting. A two-state FSM accepts one request at a time from the first
// eligible region at or after the round-robin pointer. It issues the grant on
// two independent downstream handshakes: the DMA request and the data-mux
// ordering token. It then waits for both handshakes before accepting again.
// Each region keeps a count of outstanding transfers. The count rises on
// acceptance and falls on a completion pulse. Regions at MAX_OUT are masked
// out until a completion arrives.

module dma_credit_sched #(
    parameter  int N_REQ    = 4,
    parameter  int LEN_BITS = 28,
    parameter  int MAX_OUT  = 8,
    localparam int ID_W     = (N_REQ > 1) ? $clog2(N_REQ) : 1,
    localparam int CNT_W    = $clog2(MAX_OUT + 1)
) (
    input  logic                      aclk,
    input  logic                      aresetn,
    // Upstream per-region requests
    input  logic [N_REQ-1:0]          s_req_valid,
    output logic [N_REQ-1:0]          s_req_ready,
    input  logic [N_REQ*LEN_BITS-1:0] s_req_len,
    // Downstream DMA request
    output logic                      m_req_valid,
    input  logic                      m_req_ready,
    output logic [LEN_BITS-1:0]       m_req_len,
    output logic [ID_W-1:0]           m_req_id,
    // Data-mux ordering token
    output logic                      m_mux_valid,
    input  logic                      m_mux_ready,
    output logic [ID_W-1:0]           m_mux_id,
    // Completion and status
    input  logic [N_REQ-1:0]          xfer_done,
    output logic [N_REQ*CNT_W-1:0]    out_cnt,
    output logic                      err_underflow
);

    typedef enum logic {
        IDLE = 1'b0,
        SEND = 1'b1
    } state_e;

    localparam logic [CNT_W-1:0] MAX_CNT = CNT_W'(MAX_OUT);
    localparam logic [ID_W-1:0]  LAST_ID = ID_W'(N_REQ - 1);

    state_e                state_q,       state_d;
    logic [ID_W-1:0]       rr_ptr_q,      rr_ptr_d;
    logic                  m_req_valid_q, m_req_valid_d;
    logic                  m_mux_valid_q, m_mux_valid_d;
    logic [LEN_BITS-1:0]   len_q,         len_d;
    logic [ID_W-1:0]       id_q,          id_d;
    logic                  err_q,         err_d;
    logic [CNT_W-1:0]      cnt_q [N_REQ];
    logic [CNT_W-1:0]      cnt_d [N_REQ];

    logic [N_REQ-1:0]      eligible;
    logic [N_REQ-1:0]      grant_oh;
    logic                  grant_any;
    logic [ID_W-1:0]       grant_id;
    logic                  req_fire;
    logic                  mux_fire;
    logic                  req_done;
    logic                  mux_done;

    // A region may be picked only while it has credit left.
    for (genvar g = 0; g < N_REQ; g++) begin : g_region
        assign eligible[g]                  = s_req_valid[g] && (cnt_q[g] < MAX_CNT);
        assign out_cnt[g*CNT_W +: CNT_W]    = cnt_q[g];
    end

    // Round-robin search from rr_ptr; the accept is only offered in IDLE and out of reset.
    always_comb begin : pick_comb
        int              idx;
        logic [ID_W-1:0] cand;
        // NOTE: every signal driven here gets a default first so no path leaves it unassigned and no latch is inferred.
        grant_any = 1'b0;
        grant_id  = '0;
        grant_oh  = '0;
        idx       = 0;
        cand      = '0;
        for (int k = 0; k < N_REQ; k++) begin
            idx = int'(rr_ptr_q) + k;
            if (idx >= N_REQ) begin
                idx = idx - N_REQ;
            end
            cand = ID_W'(idx);
            if (!grant_any && eligible[cand]) begin
                grant_any = 1'b1;
                grant_id  = cand;
            end
        end
        // Gating with aresetn keeps s_req_ready low while reset is held.
        if ((state_q == IDLE) && grant_any && aresetn) begin
            grant_oh[grant_id] = 1'b1;
        end
    end

    assign s_req_ready = grant_oh;

    // Outstanding counters: an accept and a completion in the same cycle cancel out; a lone completion at zero flags underflow.
    always_comb begin
        err_d = err_q;
        for (int i = 0; i < N_REQ; i++) begin
            cnt_d[i] = cnt_q[i];
            unique case ({grant_oh[i], xfer_done[i]})
                2'b10: cnt_d[i] = cnt_q[i] + CNT_W'(1);
                2'b01: begin
                    if (cnt_q[i] == '0) begin
                        err_d = 1'b1;
                    end else begin
                        cnt_d[i] = cnt_q[i] - CNT_W'(1);
                    end
                end
                default: cnt_d[i] = cnt_q[i];
            endcase
        end
    end

    assign req_fire = m_req_valid_q && m_req_ready;
    assign mux_fire = m_mux_valid_q && m_mux_ready;
    // A side is finished once its valid has already dropped or is handshaking now.
    assign req_done = !m_req_valid_q || req_fire;
    assign mux_done = !m_mux_valid_q || mux_fire;

    // Next-state logic: latch the grant on accept, retire each valid on its own handshake, return to IDLE when both are done.
    always_comb begin
        state_d       = state_q;
        rr_ptr_d      = rr_ptr_q;
        m_req_valid_d = m_req_valid_q;
        m_mux_valid_d = m_mux_valid_q;
        len_d         = len_q;
        id_d          = id_q;
        unique case (state_q)
            IDLE: begin
                if (|grant_oh) begin
                    state_d       = SEND;
                    m_req_valid_d = 1'b1;
                    m_mux_valid_d = 1'b1;
                    len_d         = s_req_len[grant_id*LEN_BITS +: LEN_BITS];
                    id_d          = grant_id;
                end
            end
            SEND: begin
                if (req_fire) begin
                    m_req_valid_d = 1'b0;
                end
                if (mux_fire) begin
                    m_mux_valid_d = 1'b0;
                end
                if (req_done && mux_done) begin
                    state_d  = IDLE;
                    rr_ptr_d = (id_q == LAST_ID) ? '0 : id_q + ID_W'(1);
                end
            end
            default: state_d = IDLE;
        endcase
    end

    // State registers; asynchronous reset drops any in-flight grant.
    always_ff @(posedge aclk or negedge aresetn) begin
        if (!aresetn) begin
            state_q       <= IDLE;
            rr_ptr_q      <= '0;
            m_req_valid_q <= 1'b0;
            m_mux_valid_q <= 1'b0;
            len_q         <= '0;
            id_q          <= '0;
            err_q         <= 1'b0;
            // NOTE: the counter array is architectural state seen on out_cnt, so each entry is reset rather than left as an unreset memory.
            for (int i = 0; i < N_REQ; i++) begin
                cnt_q[i] <= '0;
            end
        end else begin
            // NOTE: non-blocking assignments let every flop sample the pre-edge values regardless of statement order.
            state_q       <= state_d;
            rr_ptr_q      <= rr_ptr_d;
            m_req_valid_q <= m_req_valid_d;
            m_mux_valid_q <= m_mux_valid_d;
            len_q         <= len_d;
            id_q          <= id_d;
            err_q         <= err_d;
            for (int i = 0; i < N_REQ; i++) begin
                cnt_q[i] <= cnt_d[i];
            end
        end
    end

    assign m_req_valid   = m_req_valid_q;
    assign m_mux_valid   = m_mux_valid_q;
    assign m_req_len     = len_q;
    assign m_req_id      = id_q;
    assign m_mux_id      = id_q;
    assign err_underflow = err_q;

endmodule

// File: doc/dma_credit_sched.md
DMA_CREDIT_SCHED -- requirements
Module: dma_credit_sched

Interface
REQ-001 Parameter N_REQ, default 4, SHALL be the number of requesting regions (1..16).
REQ-002 Parameter LEN_BITS, default 28, SHALL be the transfer length width.
REQ-003 Parameter MAX_OUT, default 8, SHALL be the max outstanding transfers per region (1..255).
REQ-004 aclk  in  1  SHALL be the sole clock; all state updates on its rising edge.
REQ-005 aresetn  in  1  SHALL be the asynchronous, active-low reset.
REQ-006 s_req_valid  in  N_REQ  SHALL be the per-region request valid.
REQ-007 s_req_ready  out  N_REQ  SHALL be the per-region accept, at most one bit high per cycle.
REQ-008 s_req_len  in  N_REQ*LEN_BITS  SHALL be the per-region transfer length, slice i for region i.
REQ-009 m_req_valid / m_req_ready  out / in  1 / 1  SHALL be the downstream DMA request handshake.
REQ-010 m_req_len  out  LEN_BITS  SHALL be the granted length.
REQ-011 m_req_id  out  clog2(N_REQ)  SHALL be the granted region index.
REQ-012 m_mux_valid / m_mux_ready  out / in  1 / 1  SHALL be the data-mux ordering handshake.
REQ-013 m_mux_id  out  clog2(N_REQ)  SHALL equal m_req_id of the same grant.
REQ-014 xfer_done  in  N_REQ  SHALL be per-region single-cycle completion pulses.
REQ-015 out_cnt  out  N_REQ*clog2(MAX_OUT+1)  SHALL expose each region's outstanding count.
REQ-016 err_underflow  out  1  SHALL be a sticky flag for a completion received at count zero.

Function
REQ-017 FSM SHALL have states IDLE and SEND.
REQ-018 Region i SHALL be eligible when s_req_valid[i]=1 and out_cnt[i] < MAX_OUT.
REQ-019 In IDLE, if any region is eligible, the block SHALL pick the first eligible index at or after rr_ptr (wrapping modulo N_REQ), assert s_req_ready for it combinationally in that cycle, latch len/id, and move to SEND.
REQ-020 In IDLE with no eligible region, s_req_ready SHALL be all-zero and the FSM SHALL remain in IDLE.
REQ-021 In SEND, s_req_ready SHALL be all-zero.
REQ-022 m_req_valid and m_mux_valid SHALL both rise in the cycle after acceptance (latency 1).
REQ-023 Each of m_req_valid and m_mux_valid SHALL drop independently in the cycle after its own valid&ready handshake, and SHALL hold stable until then.
REQ-024 The FSM SHALL return to IDLE in the cycle after both handshakes have completed; simultaneous completion SHALL behave identically.
REQ-025 On return to IDLE, rr_ptr SHALL become (granted id + 1) modulo N_REQ.
REQ-026 m_req_len, m_req_id and m_mux_id SHALL hold stable from acceptance until the return to IDLE.
REQ-027 out_cnt[i] SHALL increment on acceptance for region i and decrement on xfer_done[i].
REQ-028 An increment and a decrement in the same cycle for region i SHALL leave out_cnt[i] unchanged.
REQ-029 A decrement at out_cnt[i]=0 without a same-cycle increment SHALL hold the count at 0 and set err_underflow.
REQ-030 A count at MAX_OUT SHALL make the region ineligible, while still allowing its decrement.
REQ-031 A count that drops below MAX_OUT SHALL make the region eligible again in the next IDLE evaluation.
REQ-032 xfer_done SHALL be honoured in every state.

Reset
REQ-033 aresetn low SHALL force, asynchronously, FSM=IDLE, rr_ptr=0, all out_cnt=0, err_underflow=0, m_req_valid=0, m_mux_valid=0, s_req_ready=0, m_req_len=0, m_req_id=0 and m_mux_id=0.
REQ-034 A reset during SEND SHALL drop the in-flight grant without issuing it.
REQ-035 The first cycle after reset release SHALL evaluate eligibility from rr_ptr=0.

Verification
REQ-036 Regions 0 and 2 both valid, lengths 0x100 and 0x200, readies held high -> grant 0 (len 0x100, id 0) and then grant 2 (len 0x200, id 2), each valid one cycle after its accept.
REQ-037 m_req_ready=1 while m_mux_ready is held 0 for 3 cycles -> m_req_valid drops after 1 cycle, m_mux_valid held 3 cycles, and no new accept until the cycle after the mux handshake.
REQ-038 Region 1 continuously valid with no xfer_done and MAX_OUT=8 -> exactly 8 accepts, out_cnt[1]=8, then s_req_ready[1]=0; one xfer_done[1] pulse -> one further accept.
REQ-039 Acceptance for region 3 and xfer_done[3] in the same cycle, with out_cnt[3]=5 -> out_cnt[3] stays 5.
REQ-040 xfer_done[0] with out_cnt[0]=0 -> err_underflow=1 and stays 1, out_cnt[0]=0.
REQ-041 aresetn asserted mid-SEND -> all outputs zero immediately; after release, region 0 valid is granted first.
